// File: rtl/regfile_stream_reader_pkg.sv
// Shared definitions for the RegisterFile read-stream master.
// The DATA_WIDTH and Addr_Depth defaults match the RegisterFile instance this reader is paired with.
package regfile_stream_reader_pkg;

    localparam int RF_DATA_WIDTH = 24;
    localparam int RF_ADDR_DEPTH = 12;
    localparam int RD_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rf_stream_fifo.sv
// Synchronous FIFO holding read data between the RegisterFile and the stream output.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module rf_stream_fifo #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH      = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  logic [DATA_WIDTH-1:0]        i_data,
    input  logic                         i_pop,
    output logic [DATA_WIDTH-1:0]        o_head,
    output logic [$clog2(DEPTH):0]       o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_pop;
    logic                  w_push;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head reads as zero when empty so the stream data is quiet outside valid.
    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/regfile_stream_reader.sv
// Reads a burst of consecutive RegisterFile words and streams them out over valid/ready.
// Handshake: a word transfers on a rising clock edge where m_valid && m_ready; m_valid never retracts while stalled.
module regfile_stream_reader
    import regfile_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int Addr_Depth = RF_ADDR_DEPTH,
    parameter int FIFO_DEPTH = RD_FIFO_DEPTH
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic [Addr_Depth-1:0] base_addr,
    input  logic [Addr_Depth:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [Addr_Depth-1:0] rf_address,
    output logic                  rf_en_read,
    output logic                  rf_en_write,
    input  logic [DATA_WIDTH-1:0] rf_data_out,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output state_t                dbg_state
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int LW = Addr_Depth + 1;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [Addr_Depth-1:0] r_rf_address;
    logic                  r_rf_en_read;
    logic                  r_capture;
    logic [LW-1:0]         r_len;
    logic [LW-1:0]         r_issued;
    logic [LW-1:0]         r_xfer;
    logic [Addr_Depth-1:0] r_next_addr;

    logic [CW-1:0]         w_fifo_count;
    logic [DATA_WIDTH-1:0] w_fifo_head;
    logic                  w_m_valid;
    logic                  w_xfer;
    logic [CW:0]           w_in_use;
    logic                  w_credit_ok;
    logic                  w_issue;
    logic                  w_last_word;

    // Words already committed to the buffer: stored, on the bus this cycle, or addressed this cycle.
    assign w_in_use    = {1'b0, w_fifo_count} + (CW+1)'(r_rf_en_read) + (CW+1)'(r_capture);
    assign w_credit_ok = w_in_use < (CW+1)'(FIFO_DEPTH);
    assign w_issue     = (r_state == S_READ) && (r_issued != r_len) && w_credit_ok;
    assign w_m_valid   = (w_fifo_count != '0);
    assign w_xfer      = w_m_valid && m_ready;
    assign w_last_word = (r_xfer == (r_len - LW'(1)));

    rf_stream_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clock),
        .i_rst_n (rst),
        .i_push  (r_capture),
        .i_data  (rf_data_out),
        .i_pop   (w_xfer),
        .o_head  (w_fifo_head),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clock) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_rf_address <= '0;
            r_rf_en_read <= 1'b0;
            r_capture    <= 1'b0;
            r_len        <= '0;
            r_issued     <= '0;
            r_xfer       <= '0;
            r_next_addr  <= '0;
        end else begin
            r_capture    <= r_rf_en_read;
            r_rf_en_read <= 1'b0;
            r_done       <= 1'b0;
            if (w_xfer) begin
                r_xfer <= r_xfer + LW'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len  <= length;
                        r_xfer <= '0;
                        r_busy <= 1'b1;
                        if (length == '0) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_issued <= '0;
                        end else begin
                            // First read goes out the cycle right after start; the buffer is empty here.
                            r_state      <= S_READ;
                            r_rf_en_read <= 1'b1;
                            r_rf_address <= base_addr;
                            r_next_addr  <= base_addr + Addr_Depth'(1);
                            r_issued     <= LW'(1);
                        end
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        r_rf_en_read <= 1'b1;
                        r_rf_address <= r_next_addr;
                        r_next_addr  <= r_next_addr + Addr_Depth'(1);
                        r_issued     <= r_issued + LW'(1);
                    end
                    if (r_issued == r_len) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_xfer && w_last_word) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign rf_address  = r_rf_address;
    assign rf_en_read  = r_rf_en_read;
    assign rf_en_write = 1'b0;
    assign m_data      = w_fifo_head;
    assign m_valid     = w_m_valid;
    assign m_last      = w_m_valid && w_last_word;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_regfile_stream_reader.sv
// Directed bench for regfile_stream_reader with a behavioural RegisterFile holding mem[a] = a*3.
module tb_regfile_stream_reader;
    import regfile_stream_reader_pkg::*;

    localparam int DW = 24;
    localparam int AW = 12;

    logic          clock = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] rf_address;
    logic          rf_en_read;
    logic          rf_en_write;
    logic [DW-1:0] rf_data_out = 'z;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    state_t        dbg_state;

    int n_cmp = 0;
    int n_fail = 0;

    logic [DW-1:0] got_q[$];
    logic [AW-1:0] addr_q[$];
    int            last_cnt, last_pos, done_cyc, first_en, last_en, first_valid, issued;

    regfile_stream_reader dut (
        .clock       (clock),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .rf_address  (rf_address),
        .rf_en_read  (rf_en_read),
        .rf_en_write (rf_en_write),
        .rf_data_out (rf_data_out),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .dbg_state   (dbg_state)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        w = {{(DW-AW){1'b0}}, a};
        return w * 24'd3;
    endfunction

    // RegisterFile model: one-cycle registered read, floating data otherwise.
    always @(posedge clock) begin
        if (rf_en_read) rf_data_out <= mem_word(rf_address);
        else            rf_data_out <= 'z;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_en_read"}, rf_en_read, 0);
        check({tag, "_address"}, rf_address, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_state"}, dbg_state, S_IDLE);
    endtask

    // mode 0: ready always; 1: ready on odd cycles; 2: ready low until cycle 12.
    task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] n, input int mode,
                             input int pulse_at, input int max_cyc);
        logic [DW-1:0] prev_data;
        logic          prev_stall;
        int            cyc;
        got_q.delete();
        addr_q.delete();
        last_cnt = 0; last_pos = -1; done_cyc = -1;
        first_en = -1; last_en = -1; first_valid = -1; issued = 0;
        prev_stall = 1'b0; prev_data = '0;
        base_addr = b; length = n; start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        while (cyc <= max_cyc && done_cyc < 0) begin
            case (mode)
                1:       m_ready = (cyc % 2 == 1);
                2:       m_ready = (cyc > 12);
                default: m_ready = 1'b1;
            endcase
            if (cyc == pulse_at) begin
                start = 1'b1; base_addr = 12'd100; length = 13'd3;
            end else begin
                start = 1'b0;
            end
            check("busy_during_burst", busy, 1);
            check("rf_en_write", rf_en_write, 0);
            if (prev_stall) begin
                check("stall_valid_held", m_valid, 1);
                check("stall_data_held", m_data, prev_data);
            end
            if (rf_en_read) begin
                addr_q.push_back(rf_address);
                issued++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
            end
            check("credit_in_use_le_4", (issued - got_q.size()) <= 4, 1);
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (m_valid && m_ready) begin
                if (m_last) begin
                    last_cnt++;
                    last_pos = got_q.size();
                end
                got_q.push_back(m_data);
            end
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
            if (done) done_cyc = cyc;
            step();
            cyc++;
        end
        start = 1'b0;
        m_ready = 1'b0;
        check("done_seen_in_budget", done_cyc >= 0, 1);
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        check("word_count", got_q.size(), int'(n));
        check("addr_count", addr_q.size(), int'(n));
        for (int k = 0; k < got_q.size() && k < int'(n); k++) begin
            logic [AW-1:0] ea;
            ea = b + AW'(k);
            check("data_order", got_q[k], mem_word(ea));
        end
        for (int k = 0; k < addr_q.size() && k < int'(n); k++) begin
            logic [AW-1:0] ea;
            ea = b + AW'(k);
            check("rf_address_seq", addr_q[k], ea);
        end
        check("last_count", last_cnt, (n == 0) ? 0 : 1);
        check("last_position", last_pos, int'(n) - 1);
    endtask

    initial begin
        int xfer;
        int guard;

        // Reset state
        rst = 1'b0;
        step();
        step();
        check_idle_outputs("reset");
        check("reset_en_write", rf_en_write, 0);
        rst = 1'b1;
        step();

        // Test 1: base 10, length 4, ready always: issue 1-4, data 3-6, done at 7
        run_burst(12'd10, 13'd4, 0, -1, 40);
        check("t1_first_en_cycle", first_en, 1);
        check("t1_last_en_cycle", last_en, 4);
        check("t1_first_valid_cycle", first_valid, 3);
        check("t1_done_cycle", done_cyc, 7);
        check("t1_word0", got_q[0], 30);
        check("t1_word3", got_q[3], 39);
        step();

        // Test 2: base 0, length 8, ready toggling
        run_burst(12'd0, 13'd8, 1, -1, 80);
        step();

        // Test 3: address wrap 4094,4095,0,1
        run_burst(12'd4094, 13'd4, 0, -1, 40);
        check("t3_addr2_wrapped", addr_q[2], 0);
        check("t3_word2", got_q[2], 0);
        check("t3_word1", got_q[1], 12285);
        step();

        // Test 4: zero length
        run_burst(12'd7, 13'd0, 0, -1, 10);
        check("t4_no_read", first_en, -1);
        check("t4_no_valid", first_valid, -1);
        check("t4_done_cycle", done_cyc, 1);
        step();

        // Test 5: reset after two of six words
        base_addr = 12'd50; length = 13'd6; start = 1'b1;
        step();
        start = 1'b0;
        m_ready = 1'b1;
        xfer = 0;
        guard = 0;
        while (xfer < 2 && guard < 30) begin
            if (m_valid && m_ready) xfer++;
            if (xfer < 2) step();
            guard++;
        end
        check("t5_reached_two_words", xfer, 2);
        rst = 1'b0;
        step();
        check_idle_outputs("t5_reset");
        rst = 1'b1;
        m_ready = 1'b0;
        step();
        check("t5_inflight_dropped", m_valid, 0);
        check("t5_idle_busy", busy, 0);
        run_burst(12'd20, 13'd2, 0, -1, 30);
        check("t5_word0", got_q[0], 60);
        check("t5_word1", got_q[1], 63);
        step();

        // Test 6: start while busy is ignored; full 4096-word burst
        run_burst(12'd0, 13'd4096, 2, 5, 4400);
        check("t6_last_word", got_q[4095], mem_word(12'd4095));
        step();
        check("t6_idle_state", dbg_state, S_IDLE);
        check("t6_no_restart", rf_en_read, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
